dmem_responder: RTL and testbench

- Multi-cycle data-memory responder that services load/store requests from the pipeline's MEM stage.
- Models a fixed-latency memory and asserts a stall so the pipeline holds MEM and all upstream stages until the access completes.
- Replaces the single-cycle data memory.
- Provides the request/stall/response interface that the hazard unit and the later cache fill logic will use.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_array.sv | 28 ++
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-cycle data-memory responder.
//   state_e     : responder FSM encoding
//   LATENCY_MAX : largest supported request-to-response latency
//   COUNT_W     : width of the latency down-counter
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int LATENCY_MAX = 15;
  localparam int COUNT_W     = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-organised data array: synchronous write, combinational read.
// Contents are deliberately not reset.
//   clk   : write clock
//   wr_en : write strobe, commits wdata to word widx on the rising edge
//   widx  : write word index
//   wdata : write data
//   ridx  : read word index
//   rdata : read data (combinational)
module dmem_array #(
  parameter int DEPTH_LOG2 = 15
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] widx,
  input  logic [15:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] ridx,
  output logic [15:0]           rdata
);

  logic [15:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage. Accepts one load or
// store in IDLE, freezes the pipeline while the access is in flight, and
// pulses resp_valid exactly LATENCY cycles after the accepting edge.
// LATENCY must lie in 1..LATENCY_MAX.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (accept on valid & ready)
//   req_wr                : 1 = store, 0 = load
//   req_addr, req_wdata   : byte address (bit 0 must be 0), store data
//   stall                 : pipeline freeze, combinational
//   resp_valid            : one-cycle completion pulse
//   resp_rdata            : load data with resp_valid, 0 otherwise
//   resp_err              : misaligned-access flag, pulses with resp_valid
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a request; stall follows req_valid
// BUSY  | access in flight; counter runs down to 1
// RESP  | one-cycle response; a store commits on the edge leaving RESP
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              resp_valid,
  output logic [15:0]       resp_rdata,
  output logic              resp_err
);

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 wr_q, wr_d;
  logic [DEPTH_LOG2:0]  addr_q, addr_d;
  logic [15:0]          wdata_q, wdata_d;

  logic                 arr_wr_en;
  logic [15:0]          arr_rdata;

  // Address bits above the array are ignored, so addresses wrap.
  generate
    if (ADDR_W > DEPTH_LOG2 + 1) begin : g_addr_wrap
      logic unused_addr_hi;
      assign unused_addr_hi = ^req_addr[ADDR_W-1:DEPTH_LOG2+1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    req_ready  = 1'b0;
    stall      = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    arr_wr_en  = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        // The state register is already IDLE during reset; gating with
        // rst_n keeps stall low while reset is held.
        stall     = req_valid & rst_n;
        if (req_valid) begin
          wr_d    = req_wr;
          addr_d  = req_addr[DEPTH_LOG2:0];
          wdata_d = req_wdata;
          count_d = COUNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        stall   = 1'b1;
        count_d = count_q - COUNT_W'(1);
        if (count_q == COUNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = addr_q[0];
        if (!addr_q[0]) begin
          if (wr_q) arr_wr_en  = 1'b1;
          else      resp_rdata = arr_rdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .wr_en (arr_wr_en),
    .widx  (addr_q[DEPTH_LOG2:1]),
    .wdata (wdata_q),
    .ridx  (addr_q[DEPTH_LOG2:1]),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder. Instance a: LATENCY=4, full-size array.
// Instance b: LATENCY=1, 16-word array (exercises single-cycle latency and
// address wrap). Stimulus pushes expected responses into per-instance queues;
// monitors pop and compare whenever resp_valid is seen.
module tb_dmem_responder;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_wr, a_req_ready, a_stall, a_resp_valid, a_resp_err;
  logic [15:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic        b_req_valid, b_req_wr, b_req_ready, b_stall, b_resp_valid, b_resp_err;
  logic [15:0] b_req_addr, b_req_wdata, b_resp_rdata;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  dmem_responder #(.LATENCY(4), .ADDR_W(16), .DEPTH_LOG2(15)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_wr(a_req_wr), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .req_ready(a_req_ready), .stall(a_stall),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  dmem_responder #(.LATENCY(1), .ADDR_W(16), .DEPTH_LOG2(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_wr(b_req_wr), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .req_ready(b_req_ready), .stall(b_stall),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response monitors
  always @(negedge clk) begin
    if (a_resp_valid) begin
      check("a stall with resp_valid", a_stall, 0);
      if (q_a.size() == 0) begin
        check("a unexpected resp_valid", 1, 0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check("a resp_rdata", a_resp_rdata, e.rdata);
        check("a resp_err", a_resp_err, e.err);
      end
    end
  end

  always @(negedge clk) begin
    if (b_resp_valid) begin
      check("b stall with resp_valid", b_stall, 0);
      if (q_b.size() == 0) begin
        check("b unexpected resp_valid", 1, 0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check("b resp_rdata", b_resp_rdata, e.rdata);
        check("b resp_err", b_resp_err, e.err);
      end
    end
  end

  // One LATENCY=4 access, starting in IDLE at posedge+1. hold=0 models a
  // pipeline flush: req_valid drops after acceptance.
  task automatic access_a(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic hold, input logic [15:0] exp_rdata, input logic exp_err);
    exp_t e;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    a_req_valid = 1'b1;
    a_req_wr    = wr;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    q_a.push_back(e);
    #1;
    check("a cycle0 stall", a_stall, 1);
    check("a cycle0 req_ready", a_req_ready, 1);
    for (int i = 1; i <= 3; i++) begin
      step();
      if (!hold) a_req_valid = 1'b0;
      #1;
      check("a busy stall", a_stall, 1);
      check("a busy req_ready", a_req_ready, 0);
      check("a busy resp_valid", a_resp_valid, 0);
    end
    step();
    check("a cycle4 resp_valid", a_resp_valid, 1);
    check("a cycle4 stall", a_stall, 0);
    check("a cycle4 req_ready", a_req_ready, 0);
    a_req_valid = 1'b0;
    step();
    check("a back in idle req_ready", a_req_ready, 1);
    check("a idle resp_valid", a_resp_valid, 0);
  endtask

  task automatic access_b(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] exp_rdata, input logic exp_err);
    exp_t e;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    b_req_valid = 1'b1;
    b_req_wr    = wr;
    b_req_addr  = addr;
    b_req_wdata = wdata;
    q_b.push_back(e);
    #1;
    check("b cycle0 stall", b_stall, 1);
    check("b cycle0 req_ready", b_req_ready, 1);
    step();
    check("b cycle1 resp_valid", b_resp_valid, 1);
    check("b cycle1 stall", b_stall, 0);
    check("b cycle1 req_ready", b_req_ready, 0);
    b_req_valid = 1'b0;
    step();
    check("b cycle2 req_ready", b_req_ready, 1);
    check("b cycle2 stall", b_stall, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_wr = 1'b0; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = 1'b0; b_req_wr = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    repeat (3) step();
    check("reset resp_valid", a_resp_valid, 0);
    check("reset resp_rdata", a_resp_rdata, 0);
    check("reset resp_err", a_resp_err, 0);
    check("reset req_ready", a_req_ready, 1);
    check("reset stall", a_stall, 0);
    rst_n = 1'b1;
    step();

    // store / load round trip, then back-to-back pair
    access_a(1'b1, 16'h0010, 16'hBEEF, 1'b1, 16'h0000, 1'b0);
    access_a(1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF, 1'b0);
    access_a(1'b1, 16'h0020, 16'h1234, 1'b1, 16'h0000, 1'b0);
    access_a(1'b0, 16'h0020, 16'h0000, 1'b1, 16'h1234, 1'b0);

    // misaligned load and store
    access_a(1'b0, 16'h0011, 16'h0000, 1'b1, 16'h0000, 1'b1);
    access_a(1'b1, 16'h0011, 16'hDEAD, 1'b1, 16'h0000, 1'b1);
    access_a(1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF, 1'b0);

    // flush: req_valid drops mid-access, store still commits
    access_a(1'b1, 16'h0040, 16'h7777, 1'b0, 16'h0000, 1'b0);
    access_a(1'b0, 16'h0040, 16'h0000, 1'b1, 16'h7777, 1'b0);

    // reset mid-access: store of 0x5555 must not commit
    access_a(1'b1, 16'h0030, 16'h1111, 1'b1, 16'h0000, 1'b0);
    a_req_valid = 1'b1; a_req_wr = 1'b1; a_req_addr = 16'h0030; a_req_wdata = 16'h5555;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("midreset resp_valid", a_resp_valid, 0);
    check("midreset stall", a_stall, 0);
    check("midreset req_ready", a_req_ready, 1);
    check("midreset resp_rdata", a_resp_rdata, 0);
    check("midreset resp_err", a_resp_err, 0);
    a_req_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b1;
    step();
    access_a(1'b0, 16'h0030, 16'h0000, 1'b1, 16'h1111, 1'b0);

    // LATENCY=1 with address wrap on the 16-word array
    access_b(1'b1, 16'h0002, 16'hA5A5, 16'h0000, 1'b0);
    access_b(1'b0, 16'h0022, 16'h0000, 16'hA5A5, 1'b0);
    access_b(1'b0, 16'h0002, 16'h0000, 16'hA5A5, 1'b0);

    repeat (3) step();
    check("a responses outstanding", q_a.size(), 0);
    check("b responses outstanding", q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
